// File: rtl/fifo_wr_arbiter_if.sv
// Write-arbiter bundle: two packet requesters, the shared FIFO write port, and grant/status.
// The master modport drives requests and the FIFO full flag; the slave modport is the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] a_wd;
    logic             a_valid;
    logic             a_last;
    logic             a_ready;

    logic [WIDTH-1:0] b_wd;
    logic             b_valid;
    logic             b_last;
    logic             b_ready;

    logic [WIDTH-1:0] fifo_wd;
    logic             fifo_we;
    logic             fifo_ful;

    logic [1:0]       gnt;
    logic             pkt_done;
    logic             err;

    modport master (
        output a_wd, a_valid, a_last,
        output b_wd, b_valid, b_last,
        output fifo_ful,
        input  a_ready, b_ready,
        input  fifo_wd, fifo_we,
        input  gnt, pkt_done, err
    );

    modport slave (
        input  a_wd, a_valid, a_last,
        input  b_wd, b_valid, b_last,
        input  fifo_ful,
        output a_ready, b_ready,
        output fifo_wd, fifo_we,
        output gnt, pkt_done, err
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Packet-level round-robin arbiter between two requesters onto one FIFO write port.
// Latency: 1-cycle grant, then zero-latency write; fifo_ful stalls the granted requester, idle grants time out.
module fifo_wr_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    fifo_wr_arbiter_if.slave bus
);

    // Encoding matches the one-hot gnt output directly.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_A = 2'b01,
        GNT_B = 2'b10
    } state_t;

    localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic             last_srv, last_srv_nxt;   // 0 = A served last, 1 = B
    logic [7:0]       idle_cnt, idle_cnt_nxt;

    logic             granted;
    logic             sel_valid;
    logic             sel_last;
    logic [WIDTH-1:0] sel_wd;
    logic             accept;
    logic             timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_srv <= 1'b1;
            idle_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            last_srv <= last_srv_nxt;
            idle_cnt <= idle_cnt_nxt;
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_wd    = '0;
        case (state)
            GNT_A: begin
                sel_valid = bus.a_valid;
                sel_last  = bus.a_last;
                sel_wd    = bus.a_wd;
            end
            GNT_B: begin
                sel_valid = bus.b_valid;
                sel_last  = bus.b_last;
                sel_wd    = bus.b_wd;
            end
            default: ;
        endcase
    end

    assign granted = (state != IDLE);
    assign accept  = granted & sel_valid & ~bus.fifo_ful;
    // Full stalls keep valid high, so they never reach the timeout path.
    assign timeout = granted & ~sel_valid & (idle_cnt == IDLE_LIMIT);

    always_comb begin
        state_nxt    = state;
        last_srv_nxt = last_srv;
        idle_cnt_nxt = idle_cnt;
        case (state)
            IDLE: begin
                idle_cnt_nxt = 8'd0;
                if (bus.a_valid && bus.b_valid)
                    state_nxt = last_srv ? GNT_A : GNT_B;
                else if (bus.a_valid)
                    state_nxt = GNT_A;
                else if (bus.b_valid)
                    state_nxt = GNT_B;
            end
            GNT_A, GNT_B: begin
                if (accept) begin
                    idle_cnt_nxt = 8'd0;
                    if (sel_last) begin
                        state_nxt    = IDLE;
                        last_srv_nxt = (state == GNT_B);
                    end
                end else if (!sel_valid) begin
                    if (timeout) begin
                        state_nxt    = IDLE;
                        last_srv_nxt = (state == GNT_B);
                        idle_cnt_nxt = 8'd0;
                    end else begin
                        idle_cnt_nxt = idle_cnt + 8'd1;
                    end
                end
            end
            default: begin
                state_nxt    = IDLE;
                idle_cnt_nxt = 8'd0;
            end
        endcase
    end

    assign bus.gnt      = state;
    assign bus.a_ready  = (state == GNT_A) & ~bus.fifo_ful;
    assign bus.b_ready  = (state == GNT_B) & ~bus.fifo_ful;
    assign bus.fifo_we  = accept;
    assign bus.fifo_wd  = sel_wd;
    assign bus.pkt_done = accept & sel_last;
    assign bus.err      = timeout;

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus.gnt));
    a_no_dual_ready : assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.a_ready && bus.b_ready));
    a_done_err_excl : assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.pkt_done && bus.err));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table plus stall, timeout and mid-packet reset sequences.
module tb_fifo_wr_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    fifo_wr_arbiter_if #(.WIDTH(8)) bus ();

    fifo_wr_arbiter #(.WIDTH(8), .TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       av;
        logic       al;
        logic [7:0] awd;
        logic       bv;
        logic       bl;
        logic [7:0] bwd;
        logic       ful;
        logic [1:0] e_gnt;
        logic       e_ardy;
        logic       e_brdy;
        logic       e_we;
        logic [7:0] e_wd;
        logic       e_done;
        logic       e_err;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic al, input logic [7:0] awd,
                         input logic bv, input logic bl, input logic [7:0] bwd,
                         input logic ful);
        bus.a_valid  = av;
        bus.a_last   = al;
        bus.a_wd     = awd;
        bus.b_valid  = bv;
        bus.b_last   = bl;
        bus.b_wd     = bwd;
        bus.fifo_ful = ful;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packs every output into one word: {gnt, a_ready, b_ready, fifo_we, fifo_wd, pkt_done, err}
    function automatic logic [31:0] outs();
        return {18'd0, bus.gnt, bus.a_ready, bus.b_ready, bus.fifo_we, bus.fifo_wd, bus.pkt_done, bus.err};
    endfunction

    function automatic logic [31:0] pack(input logic [1:0] g, input logic ar, input logic br,
                                         input logic we, input logic [7:0] wd,
                                         input logic dn, input logic er);
        return {18'd0, g, ar, br, we, wd, dn, er};
    endfunction

    initial begin
        checks   = 0;
        failures = 0;

        //            av al awd    bv bl bwd    ful gnt   ar br we wd     dn er
        vecs[0]  = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 2'b00, 0, 0, 0, 8'h00, 0, 0};
        vecs[1]  = '{1, 0, 8'h11, 0, 0, 8'h00, 0, 2'b00, 0, 0, 0, 8'h00, 0, 0};
        vecs[2]  = '{1, 0, 8'h11, 0, 0, 8'h00, 0, 2'b01, 1, 0, 1, 8'h11, 0, 0};
        vecs[3]  = '{1, 0, 8'h22, 0, 0, 8'h00, 0, 2'b01, 1, 0, 1, 8'h22, 0, 0};
        vecs[4]  = '{1, 1, 8'h33, 0, 0, 8'h00, 0, 2'b01, 1, 0, 1, 8'h33, 1, 0};
        vecs[5]  = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 2'b00, 0, 0, 0, 8'h00, 0, 0};
        vecs[6]  = '{1, 0, 8'hA1, 1, 0, 8'hB1, 0, 2'b00, 0, 0, 0, 8'h00, 0, 0};
        vecs[7]  = '{1, 0, 8'hA1, 1, 0, 8'hB1, 0, 2'b10, 0, 1, 1, 8'hB1, 0, 0};
        vecs[8]  = '{1, 0, 8'hA1, 1, 1, 8'hB2, 0, 2'b10, 0, 1, 1, 8'hB2, 1, 0};
        vecs[9]  = '{1, 0, 8'hA1, 1, 0, 8'hB3, 0, 2'b00, 0, 0, 0, 8'h00, 0, 0};
        vecs[10] = '{1, 0, 8'hA1, 1, 0, 8'hB3, 0, 2'b01, 1, 0, 1, 8'hA1, 0, 0};
        vecs[11] = '{1, 1, 8'hA2, 1, 0, 8'hB3, 0, 2'b01, 1, 0, 1, 8'hA2, 1, 0};
        vecs[12] = '{0, 0, 8'h00, 1, 0, 8'hB3, 0, 2'b00, 0, 0, 0, 8'h00, 0, 0};
        vecs[13] = '{0, 0, 8'h00, 1, 0, 8'hB3, 1, 2'b10, 0, 0, 0, 8'hB3, 0, 0};
        vecs[14] = '{0, 0, 8'h00, 1, 0, 8'hB3, 0, 2'b10, 0, 1, 1, 8'hB3, 0, 0};
        vecs[15] = '{0, 0, 8'h00, 1, 1, 8'hB4, 0, 2'b10, 0, 1, 1, 8'hB4, 1, 0};
        vecs[16] = '{0, 0, 8'h00, 1, 1, 8'hB5, 0, 2'b00, 0, 0, 0, 8'h00, 0, 0};
        vecs[17] = '{0, 0, 8'h00, 1, 1, 8'hB5, 0, 2'b10, 0, 1, 1, 8'hB5, 1, 0};
        vecs[18] = '{0, 0, 8'h00, 1, 0, 8'hB6, 0, 2'b00, 0, 0, 0, 8'h00, 0, 0};
        vecs[19] = '{0, 0, 8'h00, 0, 0, 8'hB6, 0, 2'b10, 0, 1, 0, 8'hB6, 0, 0};
        vecs[20] = '{0, 0, 8'h00, 1, 1, 8'hB6, 0, 2'b10, 0, 1, 1, 8'hB6, 1, 0};
        vecs[21] = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 2'b00, 0, 0, 0, 8'h00, 0, 0};

        rst_n = 1'b0;
        drive(0, 0, 8'h00, 0, 0, 8'h00, 0);
        #12;
        chk("reset_outputs", outs(), pack(2'b00, 0, 0, 0, 8'h00, 0, 0));
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].av, vecs[i].al, vecs[i].awd, vecs[i].bv, vecs[i].bl, vecs[i].bwd, vecs[i].ful);
            #2;
            chk($sformatf("vec%0d", i), outs(),
                pack(vecs[i].e_gnt, vecs[i].e_ardy, vecs[i].e_brdy, vecs[i].e_we,
                     vecs[i].e_wd, vecs[i].e_done, vecs[i].e_err));
            tick();
        end

        // Long full stall in GNT_A: grant held, nothing written, no timeout.
        drive(1, 0, 8'hC1, 0, 0, 8'h00, 0);
        #2; chk("stall_idle", outs(), pack(2'b00, 0, 0, 0, 8'h00, 0, 0));
        tick();
        #2; chk("stall_first_beat", outs(), pack(2'b01, 1, 0, 1, 8'hC1, 0, 0));
        tick();
        for (int i = 0; i < 40; i++) begin
            drive(1, 0, 8'hC2, 0, 0, 8'h00, 1);
            #2; chk($sformatf("stall_cyc%0d", i), outs(), pack(2'b01, 0, 0, 0, 8'hC2, 0, 0));
            tick();
        end
        drive(1, 1, 8'hC2, 0, 0, 8'h00, 0);
        #2; chk("stall_resume", outs(), pack(2'b01, 1, 0, 1, 8'hC2, 1, 0));
        tick();

        // Timeout in GNT_B with A waiting; last served is A so the tie goes to B.
        drive(1, 0, 8'hE1, 1, 0, 8'hD1, 0);
        #2; chk("to_idle", outs(), pack(2'b00, 0, 0, 0, 8'h00, 0, 0));
        tick();
        #2; chk("to_b_beat", outs(), pack(2'b10, 0, 1, 1, 8'hD1, 0, 0));
        tick();
        for (int i = 1; i <= 16; i++) begin
            drive(1, 0, 8'hE1, 0, 0, 8'hD1, 0);
            #2; chk($sformatf("to_gap%0d", i), outs(),
                    pack(2'b10, 0, 1, 0, 8'hD1, 0, (i == 16)));
            tick();
        end
        #2; chk("to_after_idle", outs(), pack(2'b00, 0, 0, 0, 8'h00, 0, 0));
        tick();
        drive(1, 1, 8'hE1, 0, 0, 8'hD1, 0);
        #2; chk("to_a_granted", outs(), pack(2'b01, 1, 0, 1, 8'hE1, 1, 0));
        tick();

        // Mid-packet async reset; before it, last served is A, so only reset makes A win the tie.
        drive(1, 0, 8'hF1, 1, 0, 8'hF2, 0);
        #2; chk("rst_pre_idle", outs(), pack(2'b00, 0, 0, 0, 8'h00, 0, 0));
        tick();
        #2; chk("rst_pre_b", outs(), pack(2'b10, 0, 1, 1, 8'hF2, 0, 0));
        tick();
        rst_n = 1'b0;
        #1; chk("rst_async", outs(), pack(2'b00, 0, 0, 0, 8'h00, 0, 0));
        tick();
        chk("rst_held", outs(), pack(2'b00, 0, 0, 0, 8'h00, 0, 0));
        rst_n = 1'b1;
        #2; chk("rst_post_idle", outs(), pack(2'b00, 0, 0, 0, 8'h00, 0, 0));
        tick();
        #2; chk("rst_tie_to_a", outs(), pack(2'b01, 1, 0, 1, 8'hF1, 0, 0));
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
